// File: rtl/rst_seq_ctrl_pkg.sv
// Shared state encoding, event-counter width and saturating increment for the
// reset sequencer.
package rst_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ASSERT    = 2'd0,
        WAIT_LOCK = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int RST_COUNT_W = 8;

    function automatic logic [RST_COUNT_W-1:0] sat_inc(input logic [RST_COUNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_debounce.sv
// Pushbutton debouncer: 2-FF synchroniser followed by a stability counter that
// only accepts a new level after CYCLES consecutive disagreeing samples.
module debounce_filter #(
    parameter int CYCLES = 256
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic IN_ASYNC,
    output logic OUT_LEVEL
);

    localparam int               CNT_W    = $clog2(CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    // Any single agreeing sample restarts the count, so bounces never accumulate.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= IN_ASYNC;
            r_sync <= r_meta;
            if (r_sync != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign OUT_LEVEL = r_level;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: merges board reset, PLL lock, soft reset and pushbutton into
// one registered active-high reset request with a guaranteed post-lock width.
module rst_seq_ctrl
    import rst_seq_ctrl_pkg::*;
#(
    parameter int STRETCH_CYCLES      = 64,
    parameter int DEBOUNCE_CYCLES     = 256,
    parameter int LOCK_TIMEOUT_CYCLES = 4096
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   PLL_LOCKED,
    input  logic                   SOFT_RST,
    input  logic                   BTN_RST,
    output logic                   RST_OUT,
    output logic                   READY,
    output logic                   LOCK_TIMEOUT,
    output logic [RST_COUNT_W-1:0] RST_COUNT
);

    localparam int                 STR_W        = $clog2(STRETCH_CYCLES);
    localparam int                 TMO_W        = $clog2(LOCK_TIMEOUT_CYCLES);
    localparam logic [STR_W-1:0]   STRETCH_LAST = STR_W'(STRETCH_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST     = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);

    logic                   r_lock_meta;
    logic                   r_lock_s;
    logic                   r_btn_db_d;
    logic                   w_btn_db;
    logic                   w_btn_rise;
    logic                   w_restart;
    logic                   w_trig;

    state_t                 r_state;
    logic [STR_W-1:0]       r_stretch_cnt;
    logic [TMO_W-1:0]       r_tmo_cnt;
    logic                   r_rst_out;
    logic                   r_ready;
    logic                   r_lock_timeout;
    logic [RST_COUNT_W-1:0] r_rst_count;

    debounce_filter #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_db (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .IN_ASYNC (BTN_RST),
        .OUT_LEVEL(w_btn_db)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_btn_db_d  <= 1'b0;
        end else begin
            r_lock_meta <= PLL_LOCKED;
            r_lock_s    <= r_lock_meta;
            r_btn_db_d  <= w_btn_db;
        end
    end

    assign w_btn_rise = w_btn_db & ~r_btn_db_d;
    assign w_restart  = SOFT_RST | w_btn_rise;
    assign w_trig     = w_restart | ~r_lock_s;

    // Outputs are written alongside the state transition so that RST_OUT and
    // READY flip on the very edge that enters or leaves RUN.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state        <= ASSERT;
            r_stretch_cnt  <= '0;
            r_tmo_cnt      <= '0;
            r_rst_out      <= 1'b1;
            r_ready        <= 1'b0;
            r_lock_timeout <= 1'b0;
            r_rst_count    <= '0;
        end else begin
            case (r_state)
                ASSERT: begin
                    r_state   <= WAIT_LOCK;
                    r_tmo_cnt <= '0;
                end
                WAIT_LOCK: begin
                    if (r_lock_s) begin
                        r_state       <= HOLD;
                        r_stretch_cnt <= '0;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_lock_timeout <= 1'b1;
                        r_tmo_cnt      <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!r_lock_s) begin
                        r_state   <= WAIT_LOCK;
                        r_tmo_cnt <= '0;
                    end else if (w_restart) begin
                        r_stretch_cnt <= '0;
                    end else if (r_stretch_cnt == STRETCH_LAST) begin
                        r_state   <= RUN;
                        r_rst_out <= 1'b0;
                        r_ready   <= 1'b1;
                    end else begin
                        r_stretch_cnt <= r_stretch_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (w_trig) begin
                        r_state     <= ASSERT;
                        r_rst_out   <= 1'b1;
                        r_ready     <= 1'b0;
                        r_rst_count <= sat_inc(r_rst_count);
                    end
                end
            endcase
        end
    end

    assign RST_OUT      = r_rst_out;
    assign READY        = r_ready;
    assign LOCK_TIMEOUT = r_lock_timeout;
    assign RST_COUNT    = r_rst_count;

endmodule
